// File: rtl/decode_cycle.sv
// decode_cycle: ID stage with register file, control/immediate decode and ID/EX register.
// Define ILLEGAL_INSTR_EN to flag unknown opcodes on IllegalE.
module decode_cycle #(
    parameter int PC_W = 9,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InstrD,
    input  logic [PC_W-1:0] PCD,
    input  logic [PC_W-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [PC_W-1:0] PCE,
    output logic [PC_W-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            IllegalE
);
    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] r_rf [32];
    idex_t           r_idex;
    idex_t           w_idex;
    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic            w_reg_write, w_mem_write, w_jump, w_branch, w_alu_src, w_known;
    logic [1:0]      w_result_src, w_imm_src, w_alu_op;
    logic [2:0]      w_alu_control;
    logic            w_sub, w_illegal;
    logic [XLEN-1:0] w_imm, w_rd1, w_rd2;

    assign w_op = InstrD[6:0];
    assign w_f3 = InstrD[14:12];
    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_jump       = 1'b0;
        w_branch     = 1'b0;
        w_alu_src    = 1'b0;
        w_result_src = 2'b00;
        w_imm_src    = 2'b00;
        w_alu_op     = 2'b00;
        w_known      = 1'b1;
        case (w_op)
            7'b0000011: begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_result_src = 2'b01; end
            7'b0100011: begin w_mem_write = 1'b1; w_alu_src = 1'b1; w_imm_src = 2'b01; end
            7'b0110011: begin w_reg_write = 1'b1; w_alu_op = 2'b10; end
            7'b0010011: begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_alu_op = 2'b10; end
            7'b1100011: begin w_branch = 1'b1; w_imm_src = 2'b10; w_alu_op = 2'b01; end
            7'b1101111: begin w_reg_write = 1'b1; w_jump = 1'b1; w_imm_src = 2'b11; w_result_src = 2'b10; end
            default:    w_known = 1'b0;
        endcase
    end

    // Only register-register add/sub is split by funct7; I-type bit 30 is immediate data.
    assign w_sub = (w_op == 7'b0110011) && InstrD[30];
    assign w_alu_control = (w_alu_op == 2'b01) ? 3'b001 :
                           (w_alu_op != 2'b10) ? 3'b000 :
                           (w_f3 == 3'b000)    ? {2'b00, w_sub} :
                           (w_f3 == 3'b010)    ? 3'b101 :
                           (w_f3 == 3'b110)    ? 3'b011 :
                           (w_f3 == 3'b111)    ? 3'b010 : 3'b000;

    assign w_imm = !w_known            ? '0 :
                   (w_imm_src == 2'b00) ? {{(XLEN-12){InstrD[31]}}, InstrD[31:20]} :
                   (w_imm_src == 2'b01) ? {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]} :
                   (w_imm_src == 2'b10) ? {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0} :
                                          {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    // Writeback bypass so a same-cycle W write is seen without an extra stall.
    assign w_rd1 = (RegWriteW && RdW != 5'd0 && RdW == Rs1D) ? ResultW : r_rf[Rs1D];
    assign w_rd2 = (RegWriteW && RdW != 5'd0 && RdW == Rs2D) ? ResultW : r_rf[Rs2D];

`ifdef ILLEGAL_INSTR_EN
    assign w_illegal = !w_known;
`else
    assign w_illegal = 1'b0;
`endif

    assign w_idex = '{reg_write: w_reg_write, mem_write: w_mem_write, jump: w_jump,
                      branch: w_branch, alu_src: w_alu_src, result_src: w_result_src,
                      alu_control: w_alu_control, rd1: w_rd1, rd2: w_rd2, imm: w_imm,
                      pc: PCD, pc4: PCPlus4D, rs1: Rs1D, rs2: Rs2D, rd: InstrD[11:7],
                      illegal: w_illegal};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        else if (RegWriteW && RdW != 5'd0)
            r_rf[RdW] <= ResultW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_idex <= '0;
        else if (FlushE) r_idex <= '0;
        else             r_idex <= w_idex;
    end

    assign RegWriteE   = r_idex.reg_write;
    assign MemWriteE   = r_idex.mem_write;
    assign JumpE       = r_idex.jump;
    assign BranchE     = r_idex.branch;
    assign ALUSrcE     = r_idex.alu_src;
    assign ResultSrcE  = r_idex.result_src;
    assign ALUControlE = r_idex.alu_control;
    assign RD1E        = r_idex.rd1;
    assign RD2E        = r_idex.rd2;
    assign ImmExtE     = r_idex.imm;
    assign PCE         = r_idex.pc;
    assign PCPlus4E    = r_idex.pc4;
    assign Rs1E        = r_idex.rs1;
    assign Rs2E        = r_idex.rs2;
    assign RdE         = r_idex.rd;
    assign IllegalE    = r_idex.illegal;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed vectors plus randomized decode checked against a reference model.
module tb_decode_cycle;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] InstrD = 32'h0050_0093;
    logic [8:0]  PCD = '0, PCPlus4D = '0;
    logic        FlushE = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic [31:0] ResultW = '0;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE;
    logic [8:0]  PCE, PCPlus4E;

    decode_cycle #(.PC_W(9), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

`ifdef ILLEGAL_INSTR_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    // ctrl = {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
    typedef struct packed {
        logic [9:0]  ctrl;
        logic [31:0] imm, rd1, rd2;
        logic [8:0]  pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        flush, wen;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [9:0]  ctrl;
        logic [31:0] imm;
        logic        skip_imm;
        logic [4:0]  rd;
        logic [31:0] rd1, rd2;
        logic        ill;
    } vec_t;

    int          checks = 0, errors = 0;
    logic [31:0] mrf [32];
    out_t        act;

    assign act = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                  ImmExtE, RD1E, RD2E, PCE, PCPlus4E, Rs1E, Rs2E, RdE, IllegalE};

    task automatic chk(input string name, input out_t exp, input bit skip_imm);
        out_t a = act;
        out_t e = exp;
        if (skip_imm) begin a.imm = '0; e.imm = '0; end
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, a, e);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] idx, input logic wen,
                                            input logic [4:0] wrd, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'd0;
        if (wen && wrd == idx) return wdata;
        return mrf[idx];
    endfunction

    // Reference decode by instruction class; R-type immediate is left unchecked.
    function automatic out_t predict(input logic [31:0] ins, input logic [8:0] pc,
                                     input logic flush, input logic wen, input logic [4:0] wrd,
                                     input logic [31:0] wdata, output bit skip_imm);
        out_t  o = '0;
        string kind;
        logic  [2:0] alu;
        logic  [2:0] f3 = ins[14:12];
        case (ins[6:0])
            7'h03:   kind = "lw";
            7'h23:   kind = "sw";
            7'h33:   kind = "r";
            7'h13:   kind = "i";
            7'h63:   kind = "beq";
            7'h6F:   kind = "jal";
            default: kind = "bad";
        endcase
        skip_imm = (kind == "r");
        if (kind == "r" || kind == "i")
            alu = (f3 == 3'd0) ? ((kind == "r" && ins[30]) ? 3'd1 : 3'd0) :
                  (f3 == 3'd2) ? 3'd5 : (f3 == 3'd6) ? 3'd3 : (f3 == 3'd7) ? 3'd2 : 3'd0;
        else
            alu = (kind == "beq") ? 3'd1 : 3'd0;
        if (flush) return o;
        case (kind)
            "lw":  begin o.ctrl = {5'b10001, 2'd1, alu}; o.imm = 32'($signed(ins[31:20])); end
            "sw":  begin o.ctrl = {5'b01001, 2'd0, alu}; o.imm = 32'($signed({ins[31:25], ins[11:7]})); end
            "r":   o.ctrl = {5'b10000, 2'd0, alu};
            "i":   begin o.ctrl = {5'b10001, 2'd0, alu}; o.imm = 32'($signed(ins[31:20])); end
            "beq": begin
                o.ctrl = {5'b00010, 2'd0, alu};
                o.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            "jal": begin
                o.ctrl = {5'b10100, 2'd2, alu};
                o.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            default: o.ill = ILL_ON;
        endcase
        o.rd1 = rd_model(ins[19:15], wen, wrd, wdata);
        o.rd2 = rd_model(ins[24:20], wen, wrd, wdata);
        o.pc  = pc;
        o.pc4 = pc + 9'd4;
        o.rs1 = ins[19:15];
        o.rs2 = ins[24:20];
        o.rd  = ins[11:7];
        return o;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [8:0] pc, input logic flush,
                         input logic wen, input logic [4:0] wrd, input logic [31:0] wdata);
        InstrD = ins; PCD = pc; PCPlus4D = pc + 9'd4; FlushE = flush;
        RegWriteW = wen; RdW = wrd; ResultW = wdata;
        #1;
        checks++;
        if ({Rs1D, Rs2D} !== {ins[19:15], ins[24:20]}) begin
            errors++;
            $display("FAIL rsD got=%h expected=%h", {Rs1D, Rs2D}, {ins[19:15], ins[24:20]});
        end
    endtask

    task automatic commit(input logic wen, input logic [4:0] wrd, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        if (wen && wrd != 5'd0) mrf[wrd] = wdata;
    endtask

    task automatic rand_steps(input int n, input string name);
        for (int k = 0; k < n; k++) begin
            logic [6:0]  ops [7] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
            logic [6:0]  op = ops[$urandom_range(0, 6)];
            logic [31:0] ins;
            logic [8:0]  pc = 9'($urandom);
            logic        fl = ($urandom_range(0, 7) == 0);
            logic        wen = 1'($urandom);
            logic [4:0]  wrd = 5'($urandom);
            logic [31:0] wd = $urandom;
            bit          skip;
            out_t        e;
            if (op == 7'h00) op = 7'($urandom);
            ins = {25'($urandom), op};
            drive(ins, pc, fl, wen, wrd, wd);
            e = predict(ins, pc, fl, wen, wrd, wd, skip);
            commit(wen, wrd, wd);
            chk(name, e, skip);
        end
    endtask

    initial begin
        vec_t vecs [11];
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        vecs[0]  = '{32'h0050_0093, 0, 0, 5'd0, 32'h0,          10'b10001_00_000, 32'd5,          0, 5'd1,  32'h0,          32'h0,          0};
        vecs[1]  = '{32'h0031_81B3, 0, 1, 5'd3, 32'hDEAD_BEEF, 10'b10000_00_000, 32'd0,          1, 5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
        vecs[2]  = '{32'h0000_0033, 0, 1, 5'd0, 32'h1234_5678, 10'b10000_00_000, 32'd0,          1, 5'd0,  32'h0,          32'h0,          0};
        vecs[3]  = '{32'h0031_81B3, 0, 0, 5'd0, 32'h0,          10'b10000_00_000, 32'd0,          1, 5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
        vecs[4]  = '{32'h4020_8033, 0, 0, 5'd0, 32'h0,          10'b10000_00_001, 32'd0,          1, 5'd0,  32'h0,          32'h0,          0};
        vecs[5]  = '{32'hFE00_0EE3, 0, 0, 5'd0, 32'h0,          10'b00010_00_001, 32'hFFFF_FFFC, 0, 5'd29, 32'h0,          32'h0,          0};
        vecs[6]  = '{32'h0011_2423, 0, 0, 5'd0, 32'h0,          10'b01001_00_000, 32'd8,          0, 5'd8,  32'h0,          32'h0,          0};
        vecs[7]  = '{32'h0040_A103, 0, 0, 5'd0, 32'h0,          10'b10001_01_000, 32'd4,          0, 5'd2,  32'h0,          32'h0,          0};
        vecs[8]  = '{32'h0080_00EF, 0, 0, 5'd0, 32'h0,          10'b10100_10_000, 32'd8,          0, 5'd1,  32'h0,          32'h0,          0};
        vecs[9]  = '{32'hFFFF_FFFF, 0, 0, 5'd0, 32'h0,          10'b00000_00_000, 32'd0,          0, 5'd31, 32'h0,          32'h0,          ILL_ON};
        vecs[10] = '{32'h0050_0093, 1, 1, 5'd5, 32'hCAFE_F00D, 10'b10001_00_000, 32'd5,          0, 5'd1,  32'h0,          32'h0,          0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", '0, 0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            logic [8:0] pc = 9'(i * 4);
            out_t       e;
            drive(vecs[i].instr, pc, vecs[i].flush, vecs[i].wen, vecs[i].wrd, vecs[i].wdata);
            e = vecs[i].flush ? '0 : {vecs[i].ctrl, vecs[i].imm, vecs[i].rd1, vecs[i].rd2, pc,
                                      pc + 9'd4, vecs[i].instr[19:15], vecs[i].instr[24:20],
                                      vecs[i].rd, vecs[i].ill};
            commit(vecs[i].wen, vecs[i].wrd, vecs[i].wdata);
            chk($sformatf("vec%0d", i), e, vecs[i].skip_imm);
        end

        drive(32'h0052_8293, 9'd44, 0, 0, 5'd0, 32'h0);
        commit(0, 5'd0, 32'h0);
        chk("flush_wb_seen", {10'b10001_00_000, 32'd5, 32'hCAFE_F00D, 32'hCAFE_F00D, 9'd44, 9'd48,
                              5'd5, 5'd5, 5'd5, 1'b0}, 0);

        rand_steps(300, "rand");

        #2 rst = 1'b0;
        #1 chk("async_reset", '0, 0);
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        drive(32'h0031_81B3, 9'd8, 0, 1, 5'd7, 32'h5555_AAAA);
        @(posedge clk);
        #1 chk("reset_no_write", '0, 0);
        rst = 1'b1;
        drive(32'h0073_81B3, 9'd12, 0, 0, 5'd0, 32'h0);
        commit(0, 5'd0, 32'h0);
        chk("post_reset_regs", {10'b10000_00_000, 32'd7, 32'h0, 32'h0, 9'd12, 9'd16,
                                5'd7, 5'd7, 5'd3, 1'b0}, 1);

        rand_steps(200, "rand_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_cycle.md
# decode_cycle

Decode stage of the five-stage pipelined processor, directly downstream of the fetch stage. Consumes the fetched instruction and its PC values, reads the 32x32 register file (written back from the W stage), generates control signals and the sign-extended immediate, and registers everything into the ID/EX pipeline register for the execute stage. Also exposes source register indices to the hazard unit and accepts a flush to inject bubbles.

## Interface
Parameters:
- PC_W, 9, width of PC values
- XLEN, 32, data and instruction width

Ports:
- clk  in  1  pipeline clock, rising edge active
- rst  in  1  reset, asynchronous, active-low
- InstrD  in  XLEN  instruction from fetch
- PCD  in  PC_W  PC of InstrD
- PCPlus4D  in  PC_W  PC+4 of InstrD
- FlushE  in  1  load bubble into ID/EX instead of decoded values
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  XLEN  writeback data
- Rs1D, Rs2D  out  5  InstrD[19:15], InstrD[24:20], combinational
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1  registered controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E, ImmExtE  out  XLEN  operands, immediate
- PCE, PCPlus4E  out  PC_W  registered PCs
- Rs1E, Rs2E, RdE  out  5  registered indices (RdE = InstrD[11:7])
- IllegalE  out  1  illegal-opcode flag (see Configuration)

## Operation
- Main decode on opcode InstrD[6:0]:
  - 0000011 lw: RegWrite=1, ImmSrc=I, ALUSrc=1, ResultSrc=01, ALUOp=00
  - 0100011 sw: MemWrite=1, ImmSrc=S, ALUSrc=1, ALUOp=00
  - 0110011 R-type: RegWrite=1, ALUSrc=0, ResultSrc=00, ALUOp=10
  - 0010011 I-ALU: RegWrite=1, ImmSrc=I, ALUSrc=1, ALUOp=10
  - 1100011 beq: Branch=1, ImmSrc=B, ALUSrc=0, ALUOp=01
  - 1101111 jal: RegWrite=1, Jump=1, ImmSrc=J, ResultSrc=10
  - any other opcode (incl. all zeros): all controls 0, ImmExt=0
  - unlisted fields default 0
- ALU decode: ALUOp 00 -> 000; 01 -> 001; 10 by funct3: 000 -> 001 if opcode R-type and funct7[5]=1, else 000; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
- Immediates, sign-extended from InstrD[31]: I = {[31:20]}; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; J = {[31],[19:12],[20],[30:21],0}.
- Register file: 32 entries of XLEN; x0 reads 0 and ignores writes. Write on rising clk when RegWriteW=1 and RdW!=0. Read combinational with bypass: if RegWriteW=1, RdW!=0 and RdW equals the read index, read returns ResultW.

## Timing
- Decode-to-E latency: 1 cycle; values presented in cycle n appear on *E outputs after the rising edge ending cycle n.
- FlushE=1 at an edge: all ID/EX fields load 0 (bubble). Register file write in the same cycle still occurs.
- rst low: immediately (asynchronously) all ID/EX fields 0, all 32 registers 0; every *E output is 0 during and after reset until first edge with rst high.
- Reset asserted mid-operation discards in-flight ID/EX contents and register contents; no partial writes.
- Rs1D/Rs2D have no reset; they follow InstrD.

## Configuration
- ILLEGAL_INSTR_EN defined: unknown opcode registers IllegalE=1 (all other controls still 0); IllegalE cleared by FlushE and reset.
- Not defined: IllegalE tied to 0; port remains present.

## Test plan
- Reset: rst=0 with InstrD=0x00500093 -> all *E outputs 0; release, one edge -> RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- Writeback/bypass: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF with InstrD=0x003181B3 (add x3,x3,x3) -> RD1E=RD2E=0xDEADBEEF after the edge; write to RdW=0 -> x0 still reads 0.
- Sub/branch: InstrD=0x40208033 -> ALUControlE=001; InstrD=0xFE000EE3 (beq x0,x0,-4) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC.
- Store/load/jal: InstrD=0x00112423 -> MemWriteE=1, ImmExtE=8; 0x0040A103 -> ResultSrcE=01; 0x008000EF -> JumpE=1, ResultSrcE=10, ImmExtE=8, RdE=1.
- Flush: valid add with FlushE=1 -> all *E outputs 0 next cycle, concurrent writeback visible in later reads.
- Illegal: InstrD=0xFFFFFFFF -> controls 0; IllegalE=1 with ILLEGAL_INSTR_EN, 0 without.
